// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: fetch FSM states,
// the NOP word, default vectors and redirect-priority encoding.
package pipe_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    // Redirect sources, listed from lowest to highest priority.
    // The numeric value doubles as the priority rank.
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_JUMP   = 2'd1,
        REDIR_BRANCH = 2'd2,
        REDIR_EXC    = 2'd3
    } redirect_src_t;

    // Instruction presented when no valid word is available
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    // Default vectors
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_PC   = 32'h8000_0180;

    // Instruction size in bytes; sequential fetch step
    localparam logic [31:0] INS_BYTES = 32'd4;

    // Instructions are word aligned; the low two address bits are dropped
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : pipe_pkg

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage. Picks the highest-priority
// redirect (exception, then branch, then jump), aligns it to a word, and
// otherwise offers the sequential pc+4 so the caller can use 'target'
// as the next PC whenever it decides to advance.
module if_next_pc
    import pipe_pkg::*;
#(
    parameter logic [31:0] EXC_PC = DEFAULT_EXC_PC
) (
    input  logic [31:0] pc,
    input  logic        exc_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] target
);

    redirect_src_t src;

    // Resolve which redirect source wins; later assignments take priority
    always_comb begin
        src = REDIR_NONE;
        if (jump)         src = REDIR_JUMP;
        if (branch_taken) src = REDIR_BRANCH;
        if (exc_req)      src = REDIR_EXC;
    end

    // Produce the selected destination, word aligned, or the fall-through pc
    always_comb begin
        redirect = 1'b1;
        target   = pc + INS_BYTES;
        case (src)
            REDIR_EXC:    target = align_word(EXC_PC);
            REDIR_BRANCH: target = align_word(branch_target);
            REDIR_JUMP:   target = align_word(jump_target);
            default: begin
                redirect = 1'b0;
                target   = pc + INS_BYTES;
            end
        endcase
    end

endmodule : if_next_pc

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, talks to a ready-handshaked
// instruction memory, applies redirects, and asks the hazard unit for a
// bubble while no instruction word is available.
//
// REQ   : a request for 'pc' is outstanding; the word appears on IF_ins
//         in the cycle memory signals ready.
// HOLD  : the word came back while the pipe was stalled; it is parked in
//         ins_buf and re-presented until the stall lifts.
// DRAIN : a redirect arrived while a request was still in flight; the
//         old address is held until memory answers and the word is thrown
//         away, so memory never sees an address change mid-request.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEFAULT_EXC_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_pc_plus_4,
    output logic [31:0] IF_ins,
    output logic        if_stall_req
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic [31:0]  ins_buf;

    logic         redirect;
    logic [31:0]  next_pc;
    logic [31:0]  pc_plus_4;
    logic         hold_pc;
    logic [3:0]   stall_unused;

    // Only the IF hold bit of the stall vector matters to this stage
    assign hold_pc      = stall[0];
    assign stall_unused = stall[4:1];
    assign pc_plus_4    = pc + INS_BYTES;

    if_next_pc #(
        .EXC_PC (EXC_PC)
    ) u_next_pc (
        .pc            (pc),
        .exc_req       (exc_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (next_pc)
    );

    // Fetch FSM and PC/buffer registers; redirects always beat stall[0]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            drain_addr <= 32'h0;
            ins_buf    <= NOP_INS;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (imem_ready) begin
                        if (redirect || !hold_pc) begin
                            pc <= next_pc;
                        end else begin
                            ins_buf <= imem_rdata;
                            state   <= FETCH_HOLD;
                        end
                    end else if (redirect) begin
                        drain_addr <= pc;
                        pc         <= next_pc;
                        state      <= FETCH_DRAIN;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect || !hold_pc) begin
                        pc    <= next_pc;
                        state <= FETCH_REQ;
                    end
                end
                FETCH_DRAIN: begin
                    if (redirect) begin
                        pc <= next_pc;
                    end
                    if (imem_ready) begin
                        state <= FETCH_REQ;
                    end
                end
                default: begin
                    state <= FETCH_REQ;
                end
            endcase
        end
    end

    // Decode the memory and IF/ID-facing outputs from the current state
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = 32'h0;
        IF_pc_plus_4 = 32'h0;
        IF_ins       = NOP_INS;
        if_stall_req = 1'b0;
        if (!reset) begin
            case (state)
                FETCH_REQ: begin
                    imem_req     = 1'b1;
                    imem_addr    = pc;
                    IF_pc_plus_4 = pc_plus_4;
                    IF_ins       = imem_ready ? imem_rdata : NOP_INS;
                    if_stall_req = ~imem_ready;
                end
                FETCH_HOLD: begin
                    imem_addr    = pc;
                    IF_pc_plus_4 = pc_plus_4;
                    IF_ins       = ins_buf;
                end
                FETCH_DRAIN: begin
                    imem_req     = 1'b1;
                    imem_addr    = drain_addr;
                    if_stall_req = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. The bench plays the instruction
// memory and the hazard/redirect logic, and compares every cycle against a
// transaction-level model: an expected PC, a queue of abandoned addresses
// still owed a response, and a queue of words parked during a stall.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_VEC = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  stall = 5'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] IF_pc_plus_4;
    logic [31:0] IF_ins;
    logic        if_stall_req;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPc;
    logic [31:0] drainQ[$];
    logic [31:0] heldQ[$];

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc_req       (exc_req),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .IF_pc_plus_4  (IF_pc_plus_4),
        .IF_ins        (IF_ins),
        .if_stall_req  (if_stall_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RST_VEC;
        drainQ.delete();
        heldQ.delete();
    endtask

    // Assert reset mid-cycle, confirm outputs go quiet at once, then release
    task automatic resetDut();
        @(negedge clk);
        #2;
        reset         = 1'b1;
        imem_ready    = 1'b0;
        stall         = 5'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        exc_req       = 1'b0;
        #1;
        checkOutput("rst_req",   {31'b0, imem_req},     32'h0);
        checkOutput("rst_ins",   IF_ins,                32'h0);
        checkOutput("rst_pc4",   IF_pc_plus_4,          32'h0);
        checkOutput("rst_stall", {31'b0, if_stall_req}, 32'h0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic applyStimulus(input logic rdy, input logic [31:0] rd, input logic st0,
                                 input logic br, input logic [31:0] bt,
                                 input logic jp, input logic [31:0] jt, input logic ex);
        logic        eReq, eStall, redir;
        logic [31:0] eAddr, eIns, ePc4, tgt;
        @(negedge clk);
        imem_ready    = rdy;
        imem_rdata    = rd;
        stall         = {4'($urandom_range(0, 15)), st0};
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        exc_req       = ex;
        #1;
        if (drainQ.size() != 0) begin
            eReq = 1'b1; eAddr = drainQ[0]; eIns = 32'h0; ePc4 = 32'h0; eStall = 1'b1;
        end else if (heldQ.size() != 0) begin
            eReq = 1'b0; eAddr = mPc; eIns = heldQ[0]; ePc4 = mPc + 32'd4; eStall = 1'b0;
        end else begin
            eReq = 1'b1; eAddr = mPc; ePc4 = mPc + 32'd4; eStall = !rdy;
            eIns = rdy ? rd : 32'h0;
        end
        checkOutput("req",   {31'b0, imem_req},     {31'b0, eReq});
        checkOutput("stall", {31'b0, if_stall_req}, {31'b0, eStall});
        checkOutput("ins",   IF_ins,                eIns);
        checkOutput("pc4",   IF_pc_plus_4,          ePc4);
        if (eReq) checkOutput("addr", imem_addr, eAddr);

        redir = ex | br | jp;
        tgt   = ex ? EXC_VEC : (br ? (bt & 32'hFFFF_FFFC) : (jt & 32'hFFFF_FFFC));
        if (drainQ.size() != 0) begin
            if (redir) mPc = tgt;
            if (rdy) void'(drainQ.pop_front());
        end else if (heldQ.size() != 0) begin
            if (redir) begin
                mPc = tgt; void'(heldQ.pop_front());
            end else if (!st0) begin
                mPc = mPc + 32'd4; void'(heldQ.pop_front());
            end
        end else if (rdy) begin
            if (redir)     mPc = tgt;
            else if (!st0) mPc = mPc + 32'd4;
            else           heldQ.push_back(rd);
        end else if (redir) begin
            drainQ.push_back(mPc);
            mPc = tgt;
        end
    endtask

    task automatic fetchCycle(input logic rdy, input logic [31:0] rd, input logic st0);
        applyStimulus(rdy, rd, st0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        modelReset();
        $display("[TB] starting if_fetch_stage bench");

        // Zero-wait memory: one fetch per cycle from the reset vector
        resetDut();
        fetchCycle(1'b1, 32'h1111_1111, 1'b0);
        checkOutput("zw_addr0", imem_addr, 32'h0040_0000);
        checkOutput("zw_pc4_0", IF_pc_plus_4, 32'h0040_0004);
        fetchCycle(1'b1, 32'h2222_2222, 1'b0);
        checkOutput("zw_addr1", imem_addr, 32'h0040_0004);
        checkOutput("zw_pc4_1", IF_pc_plus_4, 32'h0040_0008);
        fetchCycle(1'b1, 32'h3333_3333, 1'b0);
        checkOutput("zw_addr2", imem_addr, 32'h0040_0008);
        checkOutput("zw_stall2", {31'b0, if_stall_req}, 32'h0);

        // Two wait states, word returns while stalled, held for three cycles
        resetDut();
        for (int i = 0; i < 2; i++) begin
            fetchCycle(1'b0, 32'hDEAD_0000, 1'b0);
            checkOutput("ws_stall", {31'b0, if_stall_req}, 32'h1);
            checkOutput("ws_addr",  imem_addr, 32'h0040_0000);
        end
        fetchCycle(1'b1, 32'h8C08_0004, 1'b1);
        checkOutput("ws_ins",   IF_ins, 32'h8C08_0004);
        checkOutput("ws_done",  {31'b0, if_stall_req}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            fetchCycle(1'b1, 32'h5555_5555, 1'b1);
            checkOutput("hold_req", {31'b0, imem_req}, 32'h0);
            checkOutput("hold_ins", IF_ins, 32'h8C08_0004);
            checkOutput("hold_pc4", IF_pc_plus_4, 32'h0040_0004);
        end
        fetchCycle(1'b0, 32'h6666_6666, 1'b0);
        fetchCycle(1'b1, 32'h7777_7777, 1'b0);
        checkOutput("hold_next", imem_addr, 32'h0040_0004);
        fetchCycle(1'b1, 32'h7777_7778, 1'b0);
        fetchCycle(1'b1, 32'h7777_7779, 1'b0);

        // Branch while 0x00400010 is outstanding: drain it, then fetch 0x00400100
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0103, 1'b0, 32'h0, 1'b0);
        checkOutput("br_addr", imem_addr, 32'h0040_0010);
        fetchCycle(1'b0, 32'h0, 1'b0);
        checkOutput("drain_addr", imem_addr, 32'h0040_0010);
        fetchCycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("drain_ins", IF_ins, 32'h0);

        // All three redirects at once: the exception vector wins
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 1'b1);
        checkOutput("br_new", imem_addr, 32'h0040_0100);
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checkOutput("exc_addr", imem_addr, 32'h8000_0180);

        // Sequential fetch past the top of the address space wraps to zero
        fetchCycle(1'b1, 32'h2, 1'b0);
        checkOutput("wrap_top", imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", IF_pc_plus_4, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while draining, then restart at the reset vector
        resetDut();
        fetchCycle(1'b1, 32'hABCD_0001, 1'b0);
        checkOutput("rst_restart", imem_addr, 32'h0040_0000);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetDut();
            end else begin
                applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 3,
                              $urandom_range(0, 11) == 0, $urandom,
                              $urandom_range(0, 11) == 0, $urandom,
                              $urandom_range(0, 19) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_stage

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; directly feeds the IF/ID register through IF_pc_plus_4 and IF_ins.
- Owns the PC and drives a ready-handshaked instruction memory that may take one or more cycles per fetch.
- Applies redirects from the ID/EX/exception logic.
- Raises if_stall_req while no valid word is available, so the hazard unit can insert a bubble (stall[0]=1, stall[1]=0).

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset
EXC_PC, 32'h8000_0180, exception vector

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
stall  in  5  hazard-unit stall vector; this block uses only stall[0] (hold PC)
branch_taken  in  1  ID-resolved branch redirect
branch_target  in  32  branch destination
jump  in  1  J/JAL/JR redirect
jump_target  in  32  jump destination
exc_req  in  1  exception redirect to EXC_PC
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_rdata  in  32  instruction word; valid when imem_ready=1
imem_ready  in  1  completes the outstanding request this cycle
IF_pc_plus_4  out  32  address of the fetched instruction + 4
IF_ins  out  32  fetched instruction; 32'h0 (NOP) when none is valid
if_stall_req  out  1  fetch not complete this cycle

Behaviour:
- Registers: pc, drain_addr, ins_buf, state in {REQ, HOLD, DRAIN}.
- Reset (async): pc=RESET_PC, state=REQ, drain_addr=0, ins_buf=0.
- While reset is high: imem_req=0, IF_ins=0, IF_pc_plus_4=0, if_stall_req=0.
- Redirect priority: exc_req > branch_taken > jump. Target[1:0] is forced to 2'b00.
- A redirect overrides stall[0].
- pc+4 wraps modulo 2^32.
- REQ state:
  - Outputs: imem_req=1, imem_addr=pc, IF_pc_plus_4=pc+4, if_stall_req=~imem_ready.
  - IF_ins = imem_rdata when imem_ready=1, else 0.
  - ready & redirect: pc<=target; stay REQ. The word on IF_ins this cycle is killed by the hazard unit via flush[0]; this block does not gate it.
  - ready & ~redirect & ~stall[0]: pc<=pc+4; stay REQ. Back-to-back fetches give one instruction per cycle when memory is zero-wait.
  - ready & ~redirect & stall[0]: ins_buf<=imem_rdata; go to HOLD.
  - ~ready & redirect: drain_addr<=pc, pc<=target; go to DRAIN.
  - ~ready & ~redirect: hold; pc unchanged.
- HOLD state:
  - Outputs: imem_req=0, IF_ins=ins_buf, IF_pc_plus_4=pc+4, if_stall_req=0.
  - redirect: pc<=target; go to REQ.
  - else ~stall[0]: pc<=pc+4; go to REQ.
  - else remain in HOLD.
- DRAIN state (discard the in-flight word for the abandoned address):
  - Outputs: imem_req=1, imem_addr=drain_addr, IF_ins=0, IF_pc_plus_4=0, if_stall_req=1.
  - A further redirect overwrites pc (latest wins).
  - On imem_ready: go to REQ; imem_rdata is dropped. A redirect in that same cycle also applies.
- Memory is never given a new address before the outstanding request completes.
- Reset mid-request returns to REQ at RESET_PC. The memory model must tolerate abandoned requests across reset.
- imem_ready in HOLD is ignored (no request is outstanding).

Decomposition:
- Shared package pipe_pkg:
  - fetch state encoding (REQ/HOLD/DRAIN)
  - NOP constant 32'h0
  - default RESET_PC/EXC_PC values
  - redirect-priority constants
- One sub-module if_next_pc: combinational redirect-priority mux plus alignment. Inputs: pc, exc_req, branch_taken/branch_target, jump/jump_target. Outputs: redirect, target.
- The FSM and registers stay in if_fetch_stage.

Test Plan:
- Reset, then zero-wait memory (imem_ready=1 always):
  - imem_addr sequence 0x00400000, 0x00400004, 0x00400008.
  - IF_pc_plus_4 sequence 0x00400004, 0x00400008, ...; if_stall_req=0 throughout.
- 2-wait-state memory at 0x00400000, rdata=0x8C080004:
  - if_stall_req=1 for 2 cycles, imem_addr stable.
  - Then IF_ins=0x8C080004 with if_stall_req=0.
- stall[0]=1 for 3 cycles when the word returns:
  - HOLD keeps IF_ins and IF_pc_plus_4 constant and imem_req=0.
  - After release, pc advances by exactly 4.
- branch_taken with branch_target=0x00400103 while the request to 0x00400010 is outstanding:
  - DRAIN holds imem_addr=0x00400010 until ready; that word is not presented (IF_ins=0).
  - Next request goes to 0x00400100.
- exc_req, branch_taken and jump asserted together with ready=1: next imem_addr=0x80000180.
- pc=0xFFFFFFFC, zero-wait, no redirect: next imem_addr=0x00000000.
- Reset asserted mid-DRAIN: immediately imem_req=0; after release, imem_addr=RESET_PC.
